// File: rtl/elastic_eager_fork_pkg.sv
// Shared constants and types for the elastic eager fork.
// Holds the global token width used by every elastic block.
package elastic_eager_fork_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned StallCntWidth   = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/elastic_eager_fork_if.sv
// Handshake bundle for the eager fork: one upstream channel and NUM_OUTPUTS branch channels.
// The slave modport is the fork side and the master modport is the driver/consumer side.
interface elastic_eager_fork_if
  import elastic_eager_fork_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 2
) ();

  data_t                   data_input;
  logic                    valid_input;
  logic                    stop_input;
  data_t [NUM_OUTPUTS-1:0] data_output;
  logic  [NUM_OUTPUTS-1:0] valid_output;
  logic  [NUM_OUTPUTS-1:0] stop_output;

  modport slave (
    input  data_input,
    input  valid_input,
    input  stop_output,
    output stop_input,
    output data_output,
    output valid_output
  );

  modport master (
    output data_input,
    output valid_input,
    output stop_output,
    input  stop_input,
    input  data_output,
    input  valid_output
  );

endinterface

// File: rtl/elastic_fork_branch.sv
// One branch of the eager fork: a sent flag plus the branch valid and accept terms.
module elastic_fork_branch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic stop_i,
  input  logic all_acc_i,
  output logic valid_o,
  output logic acc_o
);

  logic sent_q, sent_d;
  logic branch_valid;

  always_comb begin
    branch_valid = valid_i & ~sent_q;
    valid_o      = branch_valid;
    acc_o        = sent_q | (branch_valid & ~stop_i);
    // Remember acceptance only while the token is still held upstream.
    sent_d       = (valid_i & ~all_acc_i) ? acc_o : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/elastic_eager_fork.sv
// Eager fork of one elastic valid/stop channel into NUM_OUTPUTS branches.
// Define ELASTIC_FORK_STALL_CNT_EN to add the stall_count port and counter.
module elastic_eager_fork
  import elastic_eager_fork_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  elastic_eager_fork_if.slave      bus
`ifdef ELASTIC_FORK_STALL_CNT_EN
  ,
  output logic [StallCntWidth-1:0] stall_count
`endif
);

  logic [NUM_OUTPUTS-1:0] acc;
  logic                   all_acc;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_branch
    elastic_fork_branch u_branch (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .valid_i   (bus.valid_input),
      .stop_i    (bus.stop_output[i]),
      .all_acc_i (all_acc),
      .valid_o   (bus.valid_output[i]),
      .acc_o     (acc[i])
    );

    assign bus.data_output[i] = bus.data_input;
  end

  always_comb begin
    all_acc        = &acc;
    bus.stop_input = ~(bus.valid_input & all_acc);
  end

`ifdef ELASTIC_FORK_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.valid_input && bus.stop_input) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
